// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one proto_alu between NREQ requesters.
// Optional watchdog on the ALU response is enabled by defining ALU_TIMEOUT_EN.
module alu_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned width   = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_vld,
    input  logic [NREQ*width-1:0] req_opa,
    input  logic [NREQ*width-1:0] req_opb,
    input  logic [NREQ*2-1:0]     req_op,
    output logic [NREQ-1:0]       req_ack,
    output logic [NREQ-1:0]       rsp_vld,
    output logic [width-1:0]      rsp_result,
    output logic                  rsp_err,
    output logic                  alu_request,
    output logic [width-1:0]      alu_opa,
    output logic [width-1:0]      alu_opb,
    output logic [1:0]            alu_opcode,
    input  logic [width-1:0]      alu_result,
    input  logic                  alu_valid
);

    localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_param_check
        $error("alu_arbiter: NREQ must be 2..8 and TIMEOUT at least 1");
    end

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e            state_q, state_d;
    logic [PtrW-1:0]   ptr_q, ptr_d;
    logic [PtrW-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   req_ack_q, req_ack_d;
    logic [NREQ-1:0]   rsp_vld_q, rsp_vld_d;
    logic [width-1:0]  rsp_result_q, rsp_result_d;
    logic              rsp_err_q, rsp_err_d;
    logic              alu_request_q, alu_request_d;
    logic [width-1:0]  alu_opa_q, alu_opa_d;
    logic [width-1:0]  alu_opb_q, alu_opb_d;
    logic [1:0]        alu_opcode_q, alu_opcode_d;

`ifdef ALU_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    logic [CntW-1:0]   cnt_q, cnt_d;
`endif

    logic [width-1:0]  opa_arr [NREQ];
    logic [width-1:0]  opb_arr [NREQ];
    logic [1:0]        op_arr  [NREQ];

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            opa_arr[i] = req_opa[i*width +: width];
            opb_arr[i] = req_opb[i*width +: width];
            op_arr[i]  = req_op[i*2 +: 2];
        end
    end

    // Search from ptr upward, wrapping, first pending requester wins.
    logic            found;
    logic [PtrW-1:0] win;
    logic [PtrW-1:0] win_next;

    always_comb begin
        int unsigned idx;
        found = 1'b0;
        win   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req_vld[idx]) begin
                found = 1'b1;
                win   = PtrW'(idx);
            end
        end
    end

    assign win_next = (win == PtrW'(NREQ - 1)) ? '0 : win + 1'b1;

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        gnt_d         = gnt_q;
        req_ack_d     = '0;
        rsp_vld_d     = '0;
        rsp_result_d  = rsp_result_q;
        rsp_err_d     = rsp_err_q;
        alu_request_d = alu_request_q;
        alu_opa_d     = alu_opa_q;
        alu_opb_d     = alu_opb_q;
        alu_opcode_d  = alu_opcode_q;
`ifdef ALU_TIMEOUT_EN
        cnt_d         = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                // alu_valid here is a stale response and is dropped.
                if (found) begin
                    alu_opa_d      = opa_arr[win];
                    alu_opb_d      = opb_arr[win];
                    alu_opcode_d   = op_arr[win];
                    alu_request_d  = 1'b1;
                    req_ack_d[win] = 1'b1;
                    gnt_d          = win;
                    ptr_d          = win_next;
                    state_d        = StBusy;
`ifdef ALU_TIMEOUT_EN
                    cnt_d          = '0;
`endif
                end
            end
            StBusy: begin
                if (alu_valid) begin
                    alu_request_d    = 1'b0;
                    rsp_result_d     = alu_result;
                    rsp_vld_d[gnt_q] = 1'b1;
                    rsp_err_d        = 1'b0;
                    state_d          = StIdle;
`ifdef ALU_TIMEOUT_EN
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    alu_request_d    = 1'b0;
                    rsp_result_d     = '0;
                    rsp_vld_d[gnt_q] = 1'b1;
                    rsp_err_d        = 1'b1;
                    state_d          = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            ptr_q         <= '0;
            gnt_q         <= '0;
            req_ack_q     <= '0;
            rsp_vld_q     <= '0;
            rsp_result_q  <= '0;
            rsp_err_q     <= 1'b0;
            alu_request_q <= 1'b0;
            alu_opa_q     <= '0;
            alu_opb_q     <= '0;
            alu_opcode_q  <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            gnt_q         <= gnt_d;
            req_ack_q     <= req_ack_d;
            rsp_vld_q     <= rsp_vld_d;
            rsp_result_q  <= rsp_result_d;
            rsp_err_q     <= rsp_err_d;
            alu_request_q <= alu_request_d;
            alu_opa_q     <= alu_opa_d;
            alu_opb_q     <= alu_opb_d;
            alu_opcode_q  <= alu_opcode_d;
        end
    end

`ifdef ALU_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign req_ack     = req_ack_q;
    assign rsp_vld     = rsp_vld_q;
    assign rsp_result  = rsp_result_q;
    assign alu_request = alu_request_q;
    assign alu_opa     = alu_opa_q;
    assign alu_opb     = alu_opb_q;
    assign alu_opcode  = alu_opcode_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a behavioural ALU responder.
// Define ALU_TIMEOUT_EN for both files to include the watchdog scenario.
module tb_alu_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned W    = 32;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req_vld;
    logic [NREQ*W-1:0]    req_opa;
    logic [NREQ*W-1:0]    req_opb;
    logic [NREQ*2-1:0]    req_op;
    logic [NREQ-1:0]      req_ack;
    logic [NREQ-1:0]      rsp_vld;
    logic [W-1:0]         rsp_result;
    logic                 rsp_err;
    logic                 alu_request;
    logic [W-1:0]         alu_opa;
    logic [W-1:0]         alu_opb;
    logic [1:0]           alu_opcode;
    logic [W-1:0]         alu_result;
    logic                 alu_valid;

    alu_arbiter #(.NREQ(NREQ), .width(W), .TIMEOUT(64)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .req_vld    (req_vld),
        .req_opa    (req_opa),
        .req_opb    (req_opb),
        .req_op     (req_op),
        .req_ack    (req_ack),
        .rsp_vld    (rsp_vld),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .alu_request(alu_request),
        .alu_opa    (alu_opa),
        .alu_opb    (alu_opb),
        .alu_opcode (alu_opcode),
        .alu_result (alu_result),
        .alu_valid  (alu_valid)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int multi_hot = 0;
    bit alu_auto = 1'b0;
    int ack_q[$];
    int rsp_q[$];
    int res_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        int r = -1;
        for (int i = 0; i < NREQ; i++) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

    // Opcodes assumed for the ALU model: 0 ADD, 1 SUB, 2 AND, 3 OR.
    function automatic logic [W-1:0] alu_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic [1:0] op);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a | b;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_job(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [1:0] op);
        req_opa[i*W +: W] = a;
        req_opb[i*W +: W] = b;
        req_op[i*2 +: 2]  = op;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_vld   = '0;
        alu_valid = 1'b0;
        alu_auto  = 1'b0;
        repeat (2) step();
        ack_q.delete();
        rsp_q.delete();
        res_q.delete();
        reset = 1'b0;
    endtask

    task automatic wait_acks(input int n, input string tag);
        int budget = 200;
        while (ack_q.size() < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check_eq({tag, "_ack_count"}, ack_q.size(), n);
    endtask

    task automatic wait_rsps(input int n, input string tag);
        int budget = 200;
        while (rsp_q.size() < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check_eq({tag, "_rsp_count"}, rsp_q.size(), n);
    endtask

    // ALU responder: answers one cycle after alu_request is seen.
    initial begin
        forever begin
            @(negedge clk);
            if (alu_auto) begin
                if (alu_request && !alu_valid) begin
                    alu_result = alu_model(alu_opa, alu_opb, alu_opcode);
                    alu_valid  = 1'b1;
                end else begin
                    alu_valid = 1'b0;
                end
            end
        end
    end

    // Event monitor.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                if (req_ack != '0) ack_q.push_back(onehot_idx(req_ack));
                if (rsp_vld != '0) begin
                    rsp_q.push_back(onehot_idx(rsp_vld));
                    res_q.push_back(int'(rsp_result));
                end
                if ($countones(req_ack) > 1 || $countones(rsp_vld) > 1) multi_hot++;
            end
        end
    end

    initial begin
        int exp_order[5];
        int exp_res[5];
        int n;
        reset      = 1'b1;
        req_vld    = '0;
        req_opa    = '0;
        req_opb    = '0;
        req_op     = '0;
        alu_result = '0;
        alu_valid  = 1'b0;

        // Reset state
        repeat (2) step();
        check_eq("rst_alu_request", alu_request, 0);
        check_eq("rst_req_ack", req_ack, 0);
        check_eq("rst_rsp_vld", rsp_vld, 0);
        check_eq("rst_rsp_err", rsp_err, 0);
        check_eq("rst_rsp_result", rsp_result, 0);
        check_eq("rst_alu_opa", alu_opa, 0);
        check_eq("rst_alu_opcode", alu_opcode, 0);
        reset = 1'b0;
        step();

        // Single job, ALU driven by hand: 5 + 3
        set_job(0, 32'd5, 32'd3, 2'd0);
        req_vld = 4'b0001;
        step();
        check_eq("t1_ack", req_ack, 4'b0001);
        check_eq("t1_alu_request", alu_request, 1);
        check_eq("t1_alu_opa", alu_opa, 5);
        check_eq("t1_alu_opb", alu_opb, 3);
        check_eq("t1_alu_opcode", alu_opcode, 0);
        step();
        req_vld = '0;
        check_eq("t1_ack_pulse", req_ack, 0);
        check_eq("t1_request_held", alu_request, 1);
        check_eq("t1_no_rsp_yet", rsp_vld, 0);
        alu_result = 32'd8;
        alu_valid  = 1'b1;
        step();
        alu_valid = 1'b0;
        check_eq("t1_rsp_vld", rsp_vld, 4'b0001);
        check_eq("t1_rsp_result", rsp_result, 8);
        check_eq("t1_rsp_err", rsp_err, 0);
        check_eq("t1_request_drop", alu_request, 0);
        step();
        check_eq("t1_rsp_pulse", rsp_vld, 0);

        // Stale alu_valid in idle is ignored
        alu_result = 32'd99;
        alu_valid  = 1'b1;
        step();
        alu_valid = 1'b0;
        check_eq("idle_valid_no_rsp", rsp_vld, 0);
        check_eq("idle_valid_result_kept", rsp_result, 8);
        step();
        check_eq("idle_valid_no_request", alu_request, 0);

        // Fairness: all four pending, order 0,1,2,3,0
        do_reset();
        set_job(0, 32'd10, 32'd1, 2'd0);
        set_job(1, 32'd20, 32'd2, 2'd1);
        set_job(2, 32'd30, 32'd3, 2'd2);
        set_job(3, 32'd40, 32'd4, 2'd3);
        alu_auto = 1'b1;
        req_vld  = 4'b1111;
        wait_acks(5, "fair");
        req_vld = '0;
        wait_rsps(5, "fair");
        exp_order = '{0, 1, 2, 3, 0};
        exp_res   = '{11, 18, 2, 44, 11};
        for (int i = 0; i < 5; i++) begin
            if (i < ack_q.size()) check_eq($sformatf("fair_ack%0d", i), ack_q[i], exp_order[i]);
            if (i < rsp_q.size()) begin
                check_eq($sformatf("fair_rsp%0d", i), rsp_q[i], exp_order[i]);
                check_eq($sformatf("fair_res%0d", i), res_q[i], exp_res[i]);
            end
        end

        // Wrap: grant 2 moves ptr to 3, then 1001 serves 3 before 0
        do_reset();
        alu_auto = 1'b1;
        req_vld  = 4'b0100;
        wait_acks(1, "wrap_a");
        req_vld = 4'b1001;
        wait_acks(3, "wrap_b");
        req_vld = '0;
        wait_rsps(3, "wrap");
        if (ack_q.size() >= 3) begin
            check_eq("wrap_first", ack_q[0], 2);
            check_eq("wrap_second", ack_q[1], 3);
            check_eq("wrap_third", ack_q[2], 0);
        end

        // Back-to-back: 0 then 2
        do_reset();
        alu_auto = 1'b1;
        req_vld  = 4'b0101;
        step();
        check_eq("b2b_ack0", req_ack, 4'b0001);
        check_eq("b2b_opa0", alu_opa, 10);
        step();
        req_vld = 4'b0100;
        check_eq("b2b_rsp0", rsp_vld, 4'b0001);
        check_eq("b2b_rsp0_result", rsp_result, 11);
        check_eq("b2b_gap_request", alu_request, 0);
        check_eq("b2b_no_ack_with_rsp", req_ack, 0);
        step();
        req_vld = '0;
        check_eq("b2b_ack2", req_ack, 4'b0100);
        check_eq("b2b_request2", alu_request, 1);
        check_eq("b2b_opa2", alu_opa, 30);
        check_eq("b2b_rsp_clear", rsp_vld, 0);
        step();
        check_eq("b2b_rsp2", rsp_vld, 4'b0100);
        check_eq("b2b_rsp2_result", rsp_result, 2);

        // Reset while busy on requester 1
        do_reset();
        req_vld = 4'b0010;
        step();
        check_eq("rmj_ack1", req_ack, 4'b0010);
        step();
        check_eq("rmj_busy", alu_request, 1);
        reset = 1'b1;
        #1;
        check_eq("rmj_request_async_drop", alu_request, 0);
        req_vld = '0;
        n = rsp_q.size();
        repeat (2) step();
        check_eq("rmj_no_rsp", rsp_vld, 0);
        reset = 1'b0;
        step();
        check_eq("rmj_no_rsp_after", rsp_q.size(), n);
        req_vld = 4'b0101;
        step();
        check_eq("rmj_ptr_reset_grant0", req_ack, 4'b0001);
        req_vld  = '0;
        alu_auto = 1'b1;
        step();
        step();
        alu_auto  = 1'b0;
        alu_valid = 1'b0;

`ifdef ALU_TIMEOUT_EN
        // Watchdog: ALU never answers, next requester served afterwards
        do_reset();
        req_vld = 4'b0001;
        step();
        check_eq("to_ack0", req_ack, 4'b0001);
        req_vld = 4'b0010;
        n = 0;
        while (n < 200) begin
            step();
            n++;
            if (rsp_vld != '0) break;
        end
        check_eq("to_busy_cycles", n, 64);
        check_eq("to_rsp_vld", rsp_vld, 4'b0001);
        check_eq("to_rsp_err", rsp_err, 1);
        check_eq("to_rsp_result", rsp_result, 0);
        check_eq("to_request_drop", alu_request, 0);
        step();
        check_eq("to_next_ack", req_ack, 4'b0010);
        req_vld = '0;
`endif

        check_eq("onehot_ack_rsp", multi_hot, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
